// File: rtl/weight_tile_fifo.sv
// Weight-row FIFO feeding the systolic array's weight-load port.
// Circular buffer of LANES-wide rows with wrap-bit pointers, almost-full
// back-pressure and tile replay (mark / rewind / release). While a mark
// is held, rows popped since the mark stay reserved so the tile can be
// re-streamed into the array without refetching it from memory.
module weight_tile_fifo #(
  parameter int DATA_W    = 8,
  parameter int LANES     = 32,
  parameter int DEPTH     = 128,
  parameter int AFULL_LVL = DEPTH - 4
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      wr_en_i,
  input  logic [LANES*DATA_W-1:0]   data_i,
  output logic                      wr_ready_o,
  input  logic                      rd_en_i,
  input  logic                      mark_i,
  input  logic                      rewind_i,
  input  logic                      release_i,
  output logic                      valid_o,
  output logic [LANES*DATA_W-1:0]   data_o,
  output logic [$clog2(DEPTH):0]    count_o,
  output logic                      almost_full_o,
  output logic                      empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int RW = LANES * DATA_W;

  localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);
  localparam logic [PW-1:0] AFULL_P = PW'(AFULL_LVL);
  localparam logic [PW-1:0] ONE_P   = PW'(1);

  // Row storage, addressed by the pointer bits below the wrap bit.
  logic [RW-1:0] mem [DEPTH];

  // Pointers carry one extra MSB so full and empty are distinguishable.
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] mark_ptr;
  logic          mark_vld;

  logic [PW-1:0] base_ptr;
  logic [PW-1:0] held;
  logic [PW-1:0] count;
  logic          full;
  logic          empty;
  logic          wr_fire;
  logic          pop;
  logic          do_mark;

  // Occupancy: held rows include those retained behind an active mark.
  assign base_ptr = mark_vld ? mark_ptr : rd_ptr;
  assign held     = wr_ptr - base_ptr;
  assign count    = wr_ptr - rd_ptr;
  assign full     = (held == DEPTH_P);
  assign empty    = (count == '0);

  // Handshake decode; all of it depends on registered state plus requests.
  assign wr_fire = wr_en_i & ~full;
  assign pop     = rd_en_i & ~empty & ~rewind_i;
  // A rewind in the same cycle consumes the old mark, so a new mark is ignored.
  assign do_mark = mark_i & ~rewind_i;

  assign wr_ready_o    = ~full;
  assign count_o       = count;
  assign empty_o       = empty;
  assign almost_full_o = (held >= AFULL_P);

  // Storage write port.
  // NOTE: the row array has no reset; its contents are don't-care until
  // written, and leaving it unreset lets it map onto RAM.
  always_ff @(posedge clk_i) begin
    if (wr_fire) begin
      mem[wr_ptr[AW-1:0]] <= data_i;
    end
  end

  // Write pointer advances on every accepted row.
  // NOTE: every register here uses <= so all updates see pre-edge values,
  // which is what makes mark capture the read pointer before a same-cycle pop.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
    end else if (wr_fire) begin
      wr_ptr <= wr_ptr + ONE_P;
    end
  end

  // Read pointer: rewind to the mark takes priority over a pop.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr <= '0;
    end else if (rewind_i) begin
      if (mark_vld) begin
        rd_ptr <= mark_ptr;
      end
    end else if (pop) begin
      rd_ptr <= rd_ptr + ONE_P;
    end
  end

  // Tile mark: mark beats release; release alone drops the retained rows.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mark_ptr <= '0;
      mark_vld <= 1'b0;
    end else if (do_mark) begin
      mark_ptr <= rd_ptr;
      mark_vld <= 1'b1;
    end else if (release_i) begin
      mark_vld <= 1'b0;
    end
  end

  // Registered read port: data_o holds its last row between pops.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_o <= 1'b0;
      data_o  <= '0;
    end else begin
      valid_o <= pop;
      if (pop) begin
        data_o <= mem[rd_ptr[AW-1:0]];
      end
    end
  end

endmodule

// File: tb/tb_weight_tile_fifo.sv
// Self-checking bench for weight_tile_fifo (LANES=4, DEPTH=8, AFULL_LVL=6).
// A behavioural model with unbounded integer indices predicts occupancy;
// expected rows are queued when a pop is driven and compared when
// valid_o is observed.
module tb_weight_tile_fifo;

  localparam int DATA_W = 8;
  localparam int LANES  = 4;
  localparam int DEPTH  = 8;
  localparam int AFULL  = 6;
  localparam int RW     = DATA_W * LANES;

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic          wr_en;
  logic [RW-1:0] data_in;
  logic          wr_ready;
  logic          rd_en;
  logic          mark;
  logic          rewind;
  logic          rel;
  logic          valid;
  logic [RW-1:0] data_out;
  logic [3:0]    count;
  logic          afull;
  logic          empty;

  weight_tile_fifo #(
    .DATA_W   (DATA_W),
    .LANES    (LANES),
    .DEPTH    (DEPTH),
    .AFULL_LVL(AFULL)
  ) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .wr_en_i      (wr_en),
    .data_i       (data_in),
    .wr_ready_o   (wr_ready),
    .rd_en_i      (rd_en),
    .mark_i       (mark),
    .rewind_i     (rewind),
    .release_i    (rel),
    .valid_o      (valid),
    .data_o       (data_out),
    .count_o      (count),
    .almost_full_o(afull),
    .empty_o      (empty)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_errors = 0;

  // Model state
  int            m_wr, m_rd, m_mark;
  bit            m_mvld;
  logic [RW-1:0] m_last;
  logic [RW-1:0] hist [int];
  logic [RW-1:0] exp_q [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [RW-1:0] row_of(input int n);
    logic [RW-1:0] r;
    for (int k = 0; k < LANES; k++) r[k*DATA_W +: DATA_W] = 8'(n * 16 + k);
    return r;
  endfunction

  task automatic model_reset();
    m_wr = 0; m_rd = 0; m_mark = 0; m_mvld = 0; m_last = '0;
    exp_q.delete();
  endtask

  // One clock cycle: drive inputs at edge+1, check combinational outputs
  // against the model's pre-edge state, update the model, then check the
  // registered outputs at the following edge+1.
  task automatic step(input bit wr, input logic [RW-1:0] d, input bit rd,
                      input bit mk, input bit rw, input bit rl);
    int base, held, cnt, old_rd;
    bit acc, pop;
    logic [RW-1:0] e;
    wr_en = wr; data_in = d; rd_en = rd; mark = mk; rewind = rw; rel = rl;
    base = m_mvld ? m_mark : m_rd;
    held = m_wr - base;
    cnt  = m_wr - m_rd;
    check("wr_ready", wr_ready, held != DEPTH);
    check("count", count, cnt);
    check("empty", empty, cnt == 0);
    check("afull", afull, held >= AFULL);
    acc    = wr && (held != DEPTH);
    pop    = rd && (cnt != 0) && !rw;
    old_rd = m_rd;
    if (acc) begin
      hist[m_wr] = d;
      m_wr++;
    end
    if (rw) begin
      if (m_mvld) m_rd = m_mark;
    end else if (pop) begin
      exp_q.push_back(hist[m_rd]);
      m_rd++;
    end
    if (mk && !rw) begin
      m_mark = old_rd;
      m_mvld = 1;
    end else if (rl) begin
      m_mvld = 0;
    end
    @(posedge clk_i); #1;
    check("valid", valid, pop);
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check("data", data_out, e);
      m_last = e;
    end else begin
      check("data_hold", data_out, m_last);
    end
  endtask

  task automatic idle();
    step(0, '0, 0, 0, 0, 0);
  endtask

  task automatic wr_row(input logic [RW-1:0] d);
    step(1, d, 0, 0, 0, 0);
  endtask

  task automatic pop_row();
    step(0, '0, 1, 0, 0, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_ni = 1'b0; wr_en = 0; data_in = '0; rd_en = 0; mark = 0; rewind = 0; rel = 0;
    model_reset();
    #2;
    check("rst_valid", valid, 0);
    check("rst_data", data_out, 0);
    check("rst_count", count, 0);
    check("rst_empty", empty, 1);
    check("rst_ready", wr_ready, 1);
    check("rst_afull", afull, 0);
    #10 rst_ni = 1'b1;
    @(posedge clk_i); #1;

    // Fill and drain
    for (int i = 1; i <= DEPTH; i++) begin
      wr_row(row_of(i));
      if (i == 5) check("afull_at5", afull, 0);
      if (i == 6) check("afull_at6", afull, 1);
    end
    check("fill_count", count, 8);
    check("fill_ready", wr_ready, 0);
    wr_row(row_of(9));
    check("drop9_count", count, 8);
    for (int i = 1; i <= DEPTH; i++) pop_row();
    check("drained_empty", empty, 1);
    idle();

    // Wrap-around with concurrent traffic at occupancy 3
    for (int i = 0; i < 3; i++) wr_row(RW'($urandom));
    for (int i = 0; i < 20; i++) begin
      step(1, RW'($urandom), 1, 0, 0, 0);
      check("wrap_count", count, 3);
    end
    for (int i = 0; i < 3; i++) pop_row();
    idle();

    // Replay: A..D, mark, pop 4, rewind, pop 4
    for (int i = 0; i < 4; i++) wr_row(RW'($urandom));
    step(0, '0, 0, 1, 0, 0);
    for (int i = 0; i < 4; i++) pop_row();
    step(0, '0, 0, 0, 1, 0);
    check("replay_rw_count", count, 4);
    for (int i = 0; i < 4; i++) pop_row();
    for (int i = 0; i < 4; i++) wr_row(RW'($urandom));
    check("replay_full", wr_ready, 0);
    check("replay_cnt", count, 4);
    step(0, '0, 0, 0, 0, 1);
    check("rel_ready", wr_ready, 1);
    check("rel_held", afull, 0);
    for (int i = 0; i < 4; i++) pop_row();
    idle();

    // Retention under back-pressure: mark at empty, 8 writes, 8 pops
    step(0, '0, 0, 1, 0, 0);
    for (int i = 0; i < DEPTH; i++) wr_row(RW'($urandom));
    for (int i = 0; i < DEPTH; i++) pop_row();
    check("ret_ready", wr_ready, 0);
    check("ret_empty", empty, 1);
    wr_row(RW'($urandom));
    step(1, RW'($urandom), 0, 0, 0, 1);
    check("rel_rise", wr_ready, 1);
    wr_row(RW'($urandom));
    check("post_rel_accept", count, 1);

    // Collisions
    for (int i = 0; i < 3; i++) wr_row(RW'($urandom));
    step(0, '0, 0, 1, 0, 0);
    pop_row();
    pop_row();
    step(0, '0, 1, 0, 1, 0);
    check("rw_pop_valid", valid, 0);
    check("rw_pop_count", count, 4);
    step(0, '0, 0, 0, 0, 1);
    pop_row();
    step(0, '0, 1, 0, 1, 0);
    check("nomark_rw_valid", valid, 0);
    check("nomark_rw_count", count, 3);
    step(0, '0, 0, 1, 0, 1);
    for (int i = 0; i < 3; i++) pop_row();
    for (int i = 0; i < 5; i++) wr_row(RW'($urandom));
    check("mark_rel_ready", wr_ready, 0);
    check("mark_rel_count", count, 5);
    step(0, '0, 0, 0, 0, 1);
    for (int i = 0; i < 5; i++) pop_row();
    idle();

    // Async reset during a full-rate pop burst
    for (int i = 0; i < 6; i++) wr_row(RW'($urandom));
    pop_row();
    pop_row();
    check("pre_rst_valid", valid, 1);
    rd_en = 0;
    #3 rst_ni = 1'b0;
    #1;
    check("arst_valid", valid, 0);
    check("arst_data", data_out, 0);
    check("arst_count", count, 0);
    check("arst_empty", empty, 1);
    model_reset();
    @(posedge clk_i); #2;
    rst_ni = 1'b1;
    @(posedge clk_i); #1;
    wr_row(32'hC0FFEE11);
    pop_row();
    idle();
    check("post_rst_empty", empty, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
